idct_block_fetch: RTL and testbench

- Parametrised pre-IDCT coefficient fetcher for the image decompressor.
- On each Start, it reads one BLK x BLK block of 16-bit coefficients from SRAM in raster order: all Y blocks, then U, then V.
- It writes the coefficients sign-extended to 32 bits into a selectable bank of the dual-port RAM for the CT/CS stage.
- It tracks block, channel and frame position internally and supports ping-pong banking.

---
 rtl/idct_block_fetch.sv | 209 ++++++++++++++++++++
 tb/tb_idct_block_fetch.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/idct_block_fetch.sv
// rtl/idct_block_fetch.sv - pre-IDCT coefficient block fetcher (SRAM -> dual-port RAM)
//
// Reads one BLK x BLK block of 16-bit coefficients per Start in raster order
// (all Y blocks, then U, then V) and writes them sign-extended to 32 bits
// into the dual-port RAM, optionally ping-ponging between two banks.
//
// Ports:
//    Clock, Reset      rising-edge clock, synchronous active-high reset
//    Start             request next block, sampled only in IDLE
//    Busy              block fetch in progress
//    Block_done        one-cycle pulse after the last DP write of a block
//    Frame_done        coincident with Block_done for the final V block
//    Channel           0 = Y, 1 = U, 2 = V (current/last block)
//    Bank              DP bank being written or last written
//    Block_index       global block number 0..N_TOTAL-1
//    SRAM_*            read-only SRAM port (address, data, we_n tied high)
//    DP_*              dual-port RAM write port (address, data, we)

module idct_block_fetch #(
   parameter int ADDR_W    = 18,
   parameter int BLK       = 8,
   parameter int Y_WIDTH   = 320,
   parameter int C_WIDTH   = 160,
   parameter int HEIGHT    = 240,
   parameter int BASE_ADDR = 76800,
   parameter int SRAM_LAT  = 2,
   parameter int PINGPONG  = 1,
   parameter int DP_ADDR_W = 7
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic                 Start,
   output logic                 Busy,
   output logic                 Block_done,
   output logic                 Frame_done,
   output logic [1:0]           Channel,
   output logic                 Bank,
   output logic [11:0]          Block_index,
   output logic [ADDR_W-1:0]    SRAM_address,
   input  logic [15:0]          SRAM_read_data,
   output logic                 SRAM_we_n,
   output logic [DP_ADDR_W-1:0] DP_address,
   output logic [31:0]          DP_write_data,
   output logic                 DP_we
);

   localparam int KW      = $clog2(BLK*BLK);
   localparam int CW      = $clog2(BLK);
   localparam int DW      = $clog2(SRAM_LAT+1) + 1;
   localparam int NBX_Y   = Y_WIDTH / BLK;
   localparam int NBX_C   = C_WIDTH / BLK;
   localparam int NBY     = HEIGHT / BLK;
   localparam int N_TOTAL = NBX_Y*NBY + 2*NBX_C*NBY;

   localparam logic [ADDR_W-1:0] Y_BASE      = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] U_BASE      = ADDR_W'(BASE_ADDR + Y_WIDTH*HEIGHT);
   localparam logic [ADDR_W-1:0] V_BASE      = ADDR_W'(BASE_ADDR + Y_WIDTH*HEIGHT + C_WIDTH*HEIGHT);
   localparam logic [ADDR_W-1:0] Y_ROW_STEP  = ADDR_W'(Y_WIDTH - (BLK-1));
   localparam logic [ADDR_W-1:0] C_ROW_STEP  = ADDR_W'(C_WIDTH - (BLK-1));
   localparam logic [ADDR_W-1:0] Y_BROW_STEP = ADDR_W'(Y_WIDTH*BLK);
   localparam logic [ADDR_W-1:0] C_BROW_STEP = ADDR_W'(C_WIDTH*BLK);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t              state, state_n;
   logic [CW-1:0]       r_cnt, c_cnt;
   logic [11:0]         bc, br;
   logic [DW-1:0]       drain_cnt;
   logic [ADDR_W-1:0]   blk_addr;    // element (0,0) of the next block
   logic [ADDR_W-1:0]   row_base;    // element (0,0) of the current block row
   logic [ADDR_W-1:0]   next_addr;   // address to present on the next ISSUE edge
   logic                issue;
   logic                last_elem;
   logic [SRAM_LAT:0]   pipe_v;      // issue valid delayed to line up with read data
   logic [KW-1:0]       pipe_k [SRAM_LAT+1];
   logic                is_y;
   logic [ADDR_W-1:0]   row_step, brow_step, next_row_base;
   logic [11:0]         nbx_last;
   logic                bank_bit;

   assign is_y          = (Channel == 2'd0);
   assign row_step      = is_y ? Y_ROW_STEP : C_ROW_STEP;
   assign brow_step     = is_y ? Y_BROW_STEP : C_BROW_STEP;
   assign nbx_last      = is_y ? 12'(NBX_Y-1) : 12'(NBX_C-1);
   assign next_row_base = row_base + brow_step;
   assign last_elem     = (r_cnt == CW'(BLK-1)) && (c_cnt == CW'(BLK-1));

   assign SRAM_we_n     = 1'b1;
   assign DP_we         = pipe_v[SRAM_LAT];
   assign bank_bit      = (PINGPONG != 0) ? Bank : 1'b0;
   assign DP_address    = DP_ADDR_W'({bank_bit, pipe_k[SRAM_LAT]});
   assign DP_write_data = {{16{SRAM_read_data[15]}}, SRAM_read_data};

   always_comb begin
      state_n    = state;
      issue      = 1'b0;
      Busy       = 1'b0;
      Block_done = 1'b0;
      Frame_done = 1'b0;
      case (state)
         S_IDLE: begin
            if (Start) state_n = S_ISSUE;
         end
         S_ISSUE: begin
            issue = 1'b1;
            Busy  = 1'b1;
            if (last_elem) state_n = S_DRAIN;
         end
         S_DRAIN: begin
            Busy = 1'b1;
            if (drain_cnt == DW'(SRAM_LAT)) state_n = S_DONE;
         end
         S_DONE: begin
            Block_done = 1'b1;
            Frame_done = (Block_index == 12'(N_TOTAL-1));
            state_n    = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state        <= S_IDLE;
         r_cnt        <= '0;
         c_cnt        <= '0;
         bc           <= '0;
         br           <= '0;
         drain_cnt    <= '0;
         blk_addr     <= Y_BASE;
         row_base     <= Y_BASE;
         next_addr    <= '0;
         SRAM_address <= '0;
         Channel      <= 2'd0;
         Bank         <= 1'b0;
         Block_index  <= '0;
         pipe_v       <= '0;
         for (int i = 0; i <= SRAM_LAT; i++) pipe_k[i] <= '0;
      end else begin
         state     <= state_n;
         pipe_v[0] <= issue;
         pipe_k[0] <= {r_cnt, c_cnt};
         for (int i = 1; i <= SRAM_LAT; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_k[i] <= pipe_k[i-1];
         end
         case (state)
            S_IDLE: begin
               if (Start) begin
                  next_addr <= blk_addr;
                  r_cnt     <= '0;
                  c_cnt     <= '0;
                  drain_cnt <= '0;
               end
            end
            S_ISSUE: begin
               SRAM_address <= next_addr;
               if (c_cnt == CW'(BLK-1)) begin
                  c_cnt     <= '0;
                  r_cnt     <= r_cnt + 1'b1;
                  next_addr <= next_addr + row_step;
               end else begin
                  c_cnt     <= c_cnt + 1'b1;
                  next_addr <= next_addr + ADDR_W'(1);
               end
            end
            S_DRAIN: begin
               drain_cnt <= drain_cnt + 1'b1;
            end
            S_DONE: begin
               Block_index <= (Block_index == 12'(N_TOTAL-1)) ? 12'd0 : Block_index + 12'd1;
               if (PINGPONG != 0) Bank <= ~Bank;
               if (bc == nbx_last) begin
                  bc <= '0;
                  if (br == 12'(NBY-1)) begin
                     br <= '0;
                     case (Channel)
                        2'd0: begin
                           Channel  <= 2'd1;
                           blk_addr <= U_BASE;
                           row_base <= U_BASE;
                        end
                        2'd1: begin
                           Channel  <= 2'd2;
                           blk_addr <= V_BASE;
                           row_base <= V_BASE;
                        end
                        default: begin
                           Channel  <= 2'd0;
                           blk_addr <= Y_BASE;
                           row_base <= Y_BASE;
                        end
                     endcase
                  end else begin
                     br       <= br + 12'd1;
                     row_base <= next_row_base;
                     blk_addr <= next_row_base;
                  end
               end else begin
                  bc       <= bc + 12'd1;
                  blk_addr <= blk_addr + ADDR_W'(BLK);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_idct_block_fetch.sv
// tb/tb_idct_block_fetch.sv - directed self-checking bench for idct_block_fetch
//
// Instance a: default parameters (ping-pong banking).
// Instance b: reduced frame (32/16 x 16, base 1000, PINGPONG = 0) so whole-frame
// wrap, channel changes and Frame_done are reachable in a short run.

module tb_idct_block_fetch;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int data_mode = 0;

   logic        a_reset, a_start, a_busy, a_bd, a_fd, a_bank, a_we_n, a_we;
   logic [1:0]  a_chan;
   logic [11:0] a_idx;
   logic [17:0] a_addr;
   logic [15:0] a_rdata;
   logic [6:0]  a_daddr;
   logic [31:0] a_ddata;

   logic        b_reset, b_start, b_busy, b_bd, b_fd, b_bank, b_we_n, b_we;
   logic [1:0]  b_chan;
   logic [11:0] b_idx;
   logic [17:0] b_addr;
   logic [15:0] b_rdata;
   logic [6:0]  b_daddr;
   logic [31:0] b_ddata;

   logic [17:0] a_p1 = '0, a_p2 = '0, b_p1 = '0, b_p2 = '0;

   idct_block_fetch dut_a (
      .Clock(clk), .Reset(a_reset), .Start(a_start), .Busy(a_busy),
      .Block_done(a_bd), .Frame_done(a_fd), .Channel(a_chan), .Bank(a_bank),
      .Block_index(a_idx), .SRAM_address(a_addr), .SRAM_read_data(a_rdata),
      .SRAM_we_n(a_we_n), .DP_address(a_daddr), .DP_write_data(a_ddata), .DP_we(a_we)
   );

   idct_block_fetch #(
      .Y_WIDTH(32), .C_WIDTH(16), .HEIGHT(16), .BASE_ADDR(1000), .PINGPONG(0)
   ) dut_b (
      .Clock(clk), .Reset(b_reset), .Start(b_start), .Busy(b_busy),
      .Block_done(b_bd), .Frame_done(b_fd), .Channel(b_chan), .Bank(b_bank),
      .Block_index(b_idx), .SRAM_address(b_addr), .SRAM_read_data(b_rdata),
      .SRAM_we_n(b_we_n), .DP_address(b_daddr), .DP_write_data(b_ddata), .DP_we(b_we)
   );

   function automatic logic [15:0] sram_f(input logic [17:0] ad, input int mode);
      if (mode == 1) return ad[0] ? 16'h007F : 16'hFF80;
      return ad[15:0];
   endfunction

   function automatic logic [31:0] exp_data(input int ad, input int mode);
      logic [31:0] a;
      a = ad;
      if (mode == 1) return a[0] ? 32'h0000_007F : 32'hFFFF_FF80;
      return a[15] ? {16'hFFFF, a[15:0]} : {16'h0000, a[15:0]};
   endfunction

   // SRAM with two cycles of read latency
   always @(posedge clk) begin
      a_p1 <= a_addr;
      a_p2 <= a_p1;
      b_p1 <= b_addr;
      b_p2 <= b_p1;
   end
   always_comb a_rdata = sram_f(a_p2, data_mode);
   always_comb b_rdata = sram_f(b_p2, data_mode);

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
   endtask

   task automatic drive_start(input bit sel, input logic v);
      if (sel) b_start = v;
      else     a_start = v;
   endtask

   task automatic fetch_block(input bit sel, input int idx, input int first, input int stride,
                              input int chan, input int bank, input bit frame, input bit poke,
                              input string tag);
      int errs_addr = 0, n_we = 0, errs_dp = 0, errs_done = 0, errs_frame = 0, errs_busy = 0;
      int k, ea;
      logic [17:0] ad;
      logic [6:0]  da;
      logic [31:0] dd;
      logic        we, bd, fd, bs, exp_we;
      logic [1:0]  ch;
      check_eq({tag, "_idx"}, 32'(sel ? b_idx : a_idx), idx);
      @(negedge clk);
      drive_start(sel, 1'b1);
      @(posedge clk);
      #1 drive_start(sel, 1'b0);
      for (int t = 1; t <= 72; t++) begin
         @(posedge clk);
         #1;
         ad = sel ? b_addr  : a_addr;
         da = sel ? b_daddr : a_daddr;
         dd = sel ? b_ddata : a_ddata;
         we = sel ? b_we    : a_we;
         bd = sel ? b_bd    : a_bd;
         fd = sel ? b_fd    : a_fd;
         bs = sel ? b_busy  : a_busy;
         ch = sel ? b_chan  : a_chan;
         if (t <= 64) begin
            k  = t - 1;
            ea = first + (k / 8) * stride + (k % 8);
            if (ad != 18'(ea)) errs_addr++;
            if (t == 1)  check_eq({tag, "_addr_first"}, 32'(ad), ea);
            if (t == 64) check_eq({tag, "_addr_last"}, 32'(ad), ea);
         end
         if (t == 10) check_eq({tag, "_chan"}, 32'(ch), chan);
         if (t == 72) check_eq({tag, "_addr_hold"}, 32'(ad), first + 7 * stride + 7);
         exp_we = (t >= 3 && t <= 66);
         if (we) n_we++;
         if (we !== exp_we) errs_dp++;
         else if (exp_we) begin
            k  = t - 3;
            ea = first + (k / 8) * stride + (k % 8);
            if (da != 7'(bank * 64 + k)) errs_dp++;
            if (dd != exp_data(ea, data_mode)) errs_dp++;
         end
         if (bd !== (t == 67)) errs_done++;
         if (fd !== (frame && t == 67)) errs_frame++;
         if (t <= 66 && bs !== 1'b1) errs_busy++;
         if (t >= 68 && bs !== 1'b0) errs_busy++;
         if (poke && (t == 20 || t == 67)) drive_start(sel, 1'b1);
         if (poke && (t == 22 || t == 68)) drive_start(sel, 1'b0);
      end
      check_eq({tag, "_addr_seq_errs"}, errs_addr, 0);
      check_eq({tag, "_we_count"}, n_we, 64);
      check_eq({tag, "_dp_errs"}, errs_dp, 0);
      check_eq({tag, "_block_done_errs"}, errs_done, 0);
      check_eq({tag, "_frame_done_errs"}, errs_frame, 0);
      check_eq({tag, "_busy_errs"}, errs_busy, 0);
   endtask

   // Holds Start high so each block re-triggers on the first IDLE cycle
   task automatic skip_blocks(input bit sel, input int n, input string tag);
      int seen = 0, cyc = 0;
      drive_start(sel, 1'b1);
      while (seen < n && cyc < n * 80) begin
         @(posedge clk);
         #1;
         cyc++;
         if (sel ? b_bd : a_bd) begin
            seen++;
            if (seen == n) drive_start(sel, 1'b0);
         end
      end
      drive_start(sel, 1'b0);
      check_eq({tag, "_count"}, seen, n);
      check_eq({tag, "_cycles"}, cyc, n * 69 - 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int we_after;
      a_reset = 1'b1; b_reset = 1'b1; a_start = 1'b0; b_start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_a_ctrl", 32'({a_busy, a_bd, a_fd, a_we, a_chan, a_bank}), 0);
      check_eq("rst_a_idx", 32'(a_idx), 0);
      check_eq("rst_a_addr", 32'(a_addr), 0);
      check_eq("rst_a_daddr", 32'(a_daddr), 0);
      check_eq("rst_a_we_n", 32'(a_we_n), 1);
      check_eq("rst_b_state", 32'({b_busy, b_we, b_idx, b_addr}), 0);
      a_reset = 1'b0; b_reset = 1'b0;
      @(posedge clk);
      #1;

      // instance a: default frame, ping-pong banking
      fetch_block(1'b0, 0, 76800, 320, 0, 0, 1'b0, 1'b0, "a_blk0");
      check_eq("a_bank_after0", 32'(a_bank), 1);
      check_eq("a_idx_after0", 32'(a_idx), 1);
      data_mode = 1;
      fetch_block(1'b0, 1, 76808, 320, 0, 1, 1'b0, 1'b1, "a_blk1_sign");
      data_mode = 0;
      check_eq("a_bank_after1", 32'(a_bank), 0);
      skip_blocks(1'b0, 38, "a_skip38");
      fetch_block(1'b0, 40, 79360, 320, 0, 0, 1'b0, 1'b0, "a_blk40");

      // reset in the middle of block 41 (first address 79368)
      @(negedge clk);
      a_start = 1'b1;
      @(posedge clk);
      #1 a_start = 1'b0;
      repeat (31) @(posedge clk);
      #1;
      check_eq("a_mid_addr_e30", 32'(a_addr), 79368 + 3 * 320 + 6);
      check_eq("a_mid_we_before", 32'(a_we), 1);
      a_reset = 1'b1;
      @(posedge clk);
      #1;
      check_eq("a_mid_outs", 32'({a_busy, a_bd, a_fd, a_we, a_chan, a_bank, a_idx, a_daddr}), 0);
      check_eq("a_mid_addr", 32'(a_addr), 0);
      a_reset = 1'b0;
      we_after = 0;
      repeat (5) begin
         @(posedge clk);
         #1;
         if (a_we) we_after++;
      end
      check_eq("a_mid_no_writes", we_after, 0);
      fetch_block(1'b0, 0, 76800, 320, 0, 0, 1'b0, 1'b0, "a_refetch0");

      // instance b: small frame, fixed bank
      fetch_block(1'b1, 0, 1000, 32, 0, 0, 1'b0, 1'b0, "b_blk0");
      check_eq("b_bank_fixed", 32'(b_bank), 0);
      skip_blocks(1'b1, 3, "b_skip3");
      fetch_block(1'b1, 4, 1256, 32, 0, 0, 1'b0, 1'b0, "b_blk4");
      skip_blocks(1'b1, 2, "b_skip2a");
      fetch_block(1'b1, 7, 1280, 32, 0, 0, 1'b0, 1'b0, "b_blk7");
      fetch_block(1'b1, 8, 1512, 16, 1, 0, 1'b0, 1'b0, "b_blk8_u");
      skip_blocks(1'b1, 3, "b_skip3b");
      fetch_block(1'b1, 12, 1768, 16, 2, 0, 1'b0, 1'b0, "b_blk12_v");
      skip_blocks(1'b1, 2, "b_skip2b");
      fetch_block(1'b1, 15, 1904, 16, 2, 0, 1'b1, 1'b0, "b_blk15_last");
      check_eq("b_chan_wrap", 32'(b_chan), 0);
      fetch_block(1'b1, 0, 1000, 32, 0, 0, 1'b0, 1'b0, "b_wrap0");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
